cmos_capture_data: RTL

- Downstream of the I2C sensor-configuration controller in the OV7725 camera path.
- Waits for sensor configuration to complete, then discards a fixed number of start-up frames.
- Packs the sensor's 8-bit DVP byte stream into 16-bit RGB565 pixels with a per-pixel clock enable and aligned frame/line syncs.
- Output feeds the SDRAM write FIFO.

---
 rtl/cmos_capture_if.sv | 25 ++
 rtl/cmos_capture_data.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_if.sv
// Sensor DVP inputs and packed RGB565 pixel stream of the OV7725 capture block.
// master: sensor/stimulus side; slave: cmos_capture_data.
interface cmos_capture_if;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        cmos_frame_vsync;
    logic        cmos_frame_href;
    logic        cmos_frame_clken;
    logic [15:0] cmos_frame_data;
    logic        cmos_frame_ready;
    logic [1:0]  cmos_size_err;

    modport master (
        output cmos_vsync, cmos_href, cmos_data,
        input  cmos_frame_vsync, cmos_frame_href, cmos_frame_clken,
        input  cmos_frame_data, cmos_frame_ready, cmos_size_err
    );

    modport slave (
        input  cmos_vsync, cmos_href, cmos_data,
        output cmos_frame_vsync, cmos_frame_href, cmos_frame_clken,
        output cmos_frame_data, cmos_frame_ready, cmos_size_err
    );
endinterface

// File: rtl/cmos_capture_data.sv
// OV7725 DVP capture: waits for config, skips FRAME_SKIP frames, packs bytes into RGB565.
// Define CAPTURE_SIZE_CHK_EN to enable sticky line/frame size checking on cmos_size_err.
module cmos_capture_data #(
    parameter int FRAME_SKIP = 10,
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic cmos_config_done,
    cmos_capture_if.slave bus
);

    typedef enum logic [1:0] {WAIT_CFG, SKIP, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        run_ok;

    logic        vsync_p1;
    logic        href_p1;
    logic [7:0]  data_p1;
    logic        vsync_p2;
    logic        href_p2;
    logic        phase_p1;
    logic [7:0]  hi_p1;
    logic [7:0]  frame_cnt;
    logic        vsync_rise;
    logic        pix_done;

    logic        fvsync_p2;
    logic        fhref_p2;
    logic        vld_p2;
    logic        ready_p2;
    logic [15:0] pix_p2;

    generate
        if (FRAME_SKIP < 1 || FRAME_SKIP > 255 || IMG_HDISP < 1 || IMG_VDISP < 1) begin : g_bad_param
            $error("cmos_capture_data: parameter out of range");
        end
    endgenerate

    // Stage 1: raw sensor signals, plus one-cycle history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
            vsync_p2 <= 1'b0;
            href_p2  <= 1'b0;
            phase_p1 <= 1'b0;
        end else begin
            vsync_p1 <= bus.cmos_vsync;
            href_p1  <= bus.cmos_href;
            vsync_p2 <= vsync_p1;
            href_p2  <= href_p1;
            phase_p1 <= href_p1 ? ~phase_p1 : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        data_p1 <= bus.cmos_data;
        if (href_p1 && !phase_p1)
            hi_p1 <= data_p1;
    end

    assign vsync_rise = vsync_p1 & ~vsync_p2;
    assign pix_done   = href_p1 & phase_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= WAIT_CFG;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_CFG: if (cmos_config_done) state_nxt = SKIP;
            SKIP: begin
                if (!cmos_config_done)
                    state_nxt = WAIT_CFG;
                else if (vsync_rise && frame_cnt == 8'(FRAME_SKIP))
                    state_nxt = RUN;
            end
            RUN:      if (!cmos_config_done) state_nxt = WAIT_CFG;
            default:  state_nxt = WAIT_CFG;
        endcase
    end

    // Dropping config_done gates the stream on the very next edge, so a mid-line abort never emits a pixel
    always_comb begin
        run_ok = (state == RUN) && cmos_config_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= 8'd0;
        else if (state == WAIT_CFG)
            frame_cnt <= 8'd0;
        else if (state == SKIP && vsync_rise && frame_cnt != 8'hFF)
            frame_cnt <= frame_cnt + 8'd1;
    end

    // Stage 2: output register, syncs aligned with the completed pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fvsync_p2 <= 1'b0;
            fhref_p2  <= 1'b0;
            vld_p2    <= 1'b0;
            ready_p2  <= 1'b0;
            pix_p2    <= 16'd0;
        end else begin
            fvsync_p2 <= vsync_p1 & run_ok;
            fhref_p2  <= href_p1 & run_ok;
            vld_p2    <= pix_done & run_ok;
            ready_p2  <= run_ok;
            if (pix_done && run_ok)
                pix_p2 <= {hi_p1, data_p1};
        end
    end

    assign bus.cmos_frame_vsync = fvsync_p2;
    assign bus.cmos_frame_href  = fhref_p2;
    assign bus.cmos_frame_clken = vld_p2;
    assign bus.cmos_frame_data  = pix_p2;
    assign bus.cmos_frame_ready = ready_p2;

`ifdef CAPTURE_SIZE_CHK_EN
    logic        href_fall;
    logic [10:0] pix_cnt;
    logic [9:0]  line_cnt;
    logic [1:0]  size_err;

    assign href_fall = ~href_p1 & href_p2;

    // phase_p1 still holds the line's byte parity on the href-fall cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= 11'd0;
            line_cnt <= 10'd0;
            size_err <= 2'b00;
        end else if (state != RUN) begin
            pix_cnt  <= 11'd0;
            line_cnt <= 10'd0;
            if (state == WAIT_CFG)
                size_err <= 2'b00;
        end else begin
            if (href_fall)
                pix_cnt <= 11'd0;
            else if (pix_done && run_ok)
                pix_cnt <= pix_cnt + 11'd1;
            if (vsync_rise)
                line_cnt <= 10'd0;
            else if (href_fall)
                line_cnt <= line_cnt + 10'd1;
            if (href_fall && (pix_cnt != 11'(IMG_HDISP) || phase_p1))
                size_err[0] <= 1'b1;
            if (vsync_rise && line_cnt != 10'(IMG_VDISP))
                size_err[1] <= 1'b1;
        end
    end

    assign bus.cmos_size_err = size_err;
`else
    assign bus.cmos_size_err = 2'b00;
`endif

endmodule
